// File: rtl/debug_access_bridge.sv
// Executes single-shot RF/DMEM/PC debug accesses while the core is halted.
// One transaction per command; mode must return to idle before the next one is accepted.
module debug_access_bridge #(
    parameter int unsigned DMEM_RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  mode,
    input  logic        tx_flag,
    input  logic [31:0] address_bridged,
    input  logic [31:0] data_bridged,
    input  logic        core_halted,
    input  logic [31:0] rf_rdata,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] pc_value,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic        dm_re,
    output logic [31:0] data_internal,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ModeRfWr = 3'd1;
    localparam logic [2:0] ModeDmWr = 3'd2;
    localparam logic [2:0] ModeRfRd = 3'd3;
    localparam logic [2:0] ModeDmRd = 3'd4;
    localparam logic [2:0] ModePcRd = 3'd5;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [2:0]  cmd_mode_q, cmd_mode_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        rf_we_q, rf_we_d;
    logic        dm_we_q, dm_we_d;
    logic        dm_re_q, dm_re_d;

    logic idle_mode, valid_mode, start;
    logic in_rf_ok, in_aligned, cmd_rf_ok, cmd_aligned;
    logic unused_tx_flag;

    // Upstream write indicator is informational only.
    assign unused_tx_flag = tx_flag;

    assign idle_mode   = (mode == 3'd0) || (mode == 3'd6) || (mode == 3'd7);
    assign valid_mode  = !idle_mode;
    assign start       = (state_q == StIdle) && armed_q && valid_mode && core_halted;
    assign in_rf_ok    = (address_bridged[31:5] == 27'd0);
    assign in_aligned  = (address_bridged[1:0] == 2'd0);
    assign cmd_rf_ok   = (cmd_addr_q[31:5] == 27'd0);
    assign cmd_aligned = (cmd_addr_q[1:0] == 2'd0);

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | idle_mode;
        cmd_mode_d = cmd_mode_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        rf_we_d    = 1'b0;
        dm_we_d    = 1'b0;
        dm_re_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StIssue;
                    armed_d    = 1'b0;
                    cmd_mode_d = mode;
                    cmd_addr_d = address_bridged;
                    cmd_data_d = data_bridged;
                    err_d      = 1'b0;
                    // Strobes are registered here so they are high exactly during ISSUE.
                    rf_we_d    = (mode == ModeRfWr) && in_rf_ok && (address_bridged[4:0] != 5'd0);
                    dm_we_d    = (mode == ModeDmWr) && in_aligned;
                    dm_re_d    = (mode == ModeDmRd) && in_aligned;
                end
            end
            StIssue: begin
                state_d = StDone;
                case (cmd_mode_q)
                    ModeRfWr: begin
                        if (!cmd_rf_ok) err_d = 1'b1;
                        else data_d = (cmd_addr_q[4:0] == 5'd0) ? 32'd0 : cmd_data_q;
                    end
                    ModeDmWr: begin
                        if (!cmd_aligned) err_d = 1'b1;
                        else data_d = cmd_data_q;
                    end
                    ModeRfRd: begin
                        if (!cmd_rf_ok) err_d = 1'b1;
                        else data_d = rf_rdata;
                    end
                    ModeDmRd: begin
                        if (!cmd_aligned) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = 3'(DMEM_RD_LAT);
                            state_d = StWait;
                        end
                    end
                    ModePcRd: data_d = pc_value;
                    default: ;
                endcase
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    data_d  = dm_rdata;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            cmd_mode_q <= 3'd0;
            cmd_addr_q <= 32'd0;
            cmd_data_q <= 32'd0;
            cnt_q      <= 3'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            cmd_mode_q <= cmd_mode_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rf_we_q    <= rf_we_d;
            dm_we_q    <= dm_we_d;
            dm_re_q    <= dm_re_d;
        end
    end

    assign rf_addr       = cmd_addr_q[4:0];
    assign rf_wdata      = cmd_data_q;
    assign dm_addr       = cmd_addr_q;
    assign dm_wdata      = cmd_data_q;
    assign rf_we         = rf_we_q;
    assign dm_we         = dm_we_q;
    assign dm_re         = dm_re_q;
    assign data_internal = data_q;
    assign err           = err_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

endmodule
